// File: rtl/serial_full_subtractor_if.sv
// Operand/result bus for the bit-serial subtractor.
//   master : operand source / result sink side (drives in_valid, a, b, bin, res_ready)
//   slave  : subtractor side (drives in_ready, res_valid, diff, bout, busy)
// Signals:
//   in_valid/in_ready  operand handshake; a, b, bin sampled on acceptance
//   res_valid/res_ready result handshake; diff, bout held while res_valid
//   busy               subtractor is computing or holding an unaccepted result
interface serial_full_subtractor_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, res_ready,
    input  in_ready, res_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, res_ready,
    output in_ready, res_valid, diff, bout, busy
  );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial W-bit subtractor: DIFF = A - B - BIN (mod 2^W), one bit per
// clock, LSB first, with a single borrow flip-flop between bits.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of serial_full_subtractor_if
//          (operands in via in_valid/in_ready, result out via res_valid/res_ready,
//           busy high while computing or holding a result)
module serial_full_subtractor #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_full_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [W-1:0]     a_sh_q,      a_sh_d;
  logic [W-1:0]     b_sh_q,      b_sh_d;
  logic [W-1:0]     res_sh_q,    res_sh_d;
  logic             br_q,        br_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [W-1:0]     diff_q,      diff_d;
  logic             bout_q,      bout_d;
  logic             res_valid_q, res_valid_d;

  // Full-subtractor cell on the current LSBs
  logic         x_bit;
  logic         y_bit;
  logic         d_bit;
  logic         bo_bit;
  logic [W-1:0] res_shifted;

  assign x_bit  = a_sh_q[0];
  assign y_bit  = b_sh_q[0];
  assign d_bit  = x_bit ^ y_bit ^ br_q;
  assign bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);

  // New bits enter at the MSB so the first (LSB) bit lands at position 0
  // after W shifts.
  assign res_shifted = {d_bit, res_sh_q[W-1:1]};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    res_valid_d = res_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          br_d     = bus.bin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_shifted;
        br_d     = bo_bit;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Only the completed word is published; partial bits stay internal.
          diff_d      = res_shifted;
          bout_d      = bo_bit;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.res_valid = res_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
module tb_serial_full_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_full_subtractor_if #(.W(W)) bus ();

  serial_full_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: accept, wait for result (bounded), hold under backpressure
  // for 'stall' cycles, then hand-shake. poke_at>0 pulses a stray in_valid
  // during RUN after that many edges.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int stall, input int poke_at, input bit detail,
                       output logic [W-1:0] got_diff, output logic got_bout);
    int lat;
    logic [W-1:0] prev_diff;
    @(posedge clk); #1;
    prev_diff    = bus.diff;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    if (detail) check_val("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat++;
      if (poke_at > 0 && lat == poke_at && !bus.res_valid) begin
        bus.in_valid = 1'b1;
        bus.a = 8'h11;
        bus.b = 8'h00;
        bus.bin = 1'b0;
        check_val("in_ready_run", 32'(bus.in_ready), 32'd0);
        check_val("busy_run", 32'(bus.busy), 32'd1);
        check_val("diff_hidden_run", 32'(bus.diff), 32'(prev_diff));
      end
    end
    check_val("latency", 32'(lat), 32'(W));
    got_diff = bus.diff;
    got_bout = bus.bout;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (detail) begin
        check_val("stall_valid", 32'(bus.res_valid), 32'd1);
        check_val("stall_diff", 32'(bus.diff), 32'(got_diff));
        check_val("stall_bout", 32'(bus.bout), 32'(got_bout));
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_val("res_valid_drop", 32'(bus.res_valid), 32'd0);
    check_val("in_ready_after", 32'(bus.in_ready), 32'd1);
    $display("op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d lat=%0d stall=%0d",
             a, b, bin, got_diff, got_bout, lat, stall);
  endtask

  logic [W-1:0] d;
  logic         bo;
  logic [W-1:0] ra, rb;
  logic         rbin;
  logic [W:0]   model;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_diff", 32'(bus.diff), 32'd0);
    check_val("rst_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 0, 0, 1'b1, d, bo);
    check_val("t1_diff", 32'(d), 32'h1E);
    check_val("t1_bout", 32'(bo), 32'd0);

    do_op(8'h00, 8'h01, 1'b0, 0, 0, 1'b1, d, bo);
    check_val("t2a_diff", 32'(d), 32'hFF);
    check_val("t2a_bout", 32'(bo), 32'd1);

    do_op(8'hFF, 8'hFF, 1'b1, 0, 0, 1'b1, d, bo);
    check_val("t2b_diff", 32'(d), 32'hFF);
    check_val("t2b_bout", 32'(bo), 32'd1);

    do_op(8'h80, 8'h00, 1'b1, 0, 0, 1'b1, d, bo);
    check_val("t3_diff", 32'(d), 32'h7F);
    check_val("t3_bout", 32'(bo), 32'd0);

    // Backpressure: 5 stalled cycles, accepted on the 6th
    do_op(8'h34, 8'h56, 1'b0, 5, 0, 1'b1, d, bo);
    check_val("t4_diff", 32'(d), 32'hDE);
    check_val("t4_bout", 32'(bo), 32'd1);

    // Stray in_valid during RUN must be ignored
    do_op(8'h77, 8'h22, 1'b0, 0, 3, 1'b1, d, bo);
    check_val("t5_diff", 32'(d), 32'h55);
    check_val("t5_bout", 32'(bo), 32'd0);
    @(posedge clk); #1;
    check_val("t5_no_queue", 32'(bus.busy), 32'd0);

    // Reset during RUN bit 3
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("t6_busy", 32'(bus.busy), 32'd0);
    check_val("t6_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("t6_diff", 32'(bus.diff), 32'd0);
    check_val("t6_bout", 32'(bus.bout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, 0, 0, 1'b1, d, bo);
    check_val("t6_next_diff", 32'(d), 32'h0F);
    check_val("t6_next_bout", 32'(bo), 32'd0);

    // Random sweep against a wide-subtraction model
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      model = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      do_op(ra, rb, rbin, int'($urandom_range(0, 3)), 0, 1'b0, d, bo);
      check_val("rnd_diff", 32'(d), 32'(model[W-1:0]));
      check_val("rnd_bout", 32'(bo), 32'(model[W]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
